// File: rtl/fsk_demod.sv
// fsk_demod: recovers the bit stream from an FSK carrier by measuring the
// rising-edge-to-rising-edge period in RX_CLK cycles, classifying each period
// as fast or slow and filtering the class through a consecutive-period
// confirmation counter. Also reports carrier presence and the last period.
module fsk_demod #(
  parameter int CNT_W       = 8,
  parameter int THRESH      = 16,
  parameter int CONFIRM     = 3,
  parameter int TIMEOUT     = 200,
  parameter int FAST_IS_ONE = 1
) (
  input  logic             RX_CLK,
  input  logic             RESET,
  input  logic             FSK_IN,
  output logic             RX_DATA,
  output logic             RX_CHG,
  output logic             CARRIER,
  output logic [CNT_W-1:0] PERIOD
);

  typedef enum logic [1:0] {
    NO_CARRIER = 2'd0,
    ACQ        = 2'd1,
    LOCK       = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [31:0]      THRESH_C  = 32'(THRESH);
  localparam logic [3:0]       CONFIRM_C = 4'(CONFIRM);
  localparam logic             FAST_CLS  = (FAST_IS_ONE != 0);

  logic             s1_r, s2_r, s3_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] period_r;
  logic [3:0]       agree_r;
  logic             cand_r;
  logic             rx_data_r, rx_chg_r, carrier_r;
  state_t           state_r;

  logic             rise_s, fast_s, cls_s, timeout_s;
  logic [CNT_W-1:0] cnt_inc_s;
  state_t           state_s;
  logic [3:0]       agree_s;
  logic             cand_s, rx_data_s, rx_chg_s;

  // Edge detect and per-edge classification of the period that just ended.
  always_comb begin
    rise_s    = s2_r & ~s3_r;
    cnt_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
    fast_s    = (32'(cnt_inc_s) < THRESH_C);
    cls_s     = fast_s ? FAST_CLS : ~FAST_CLS;
    timeout_s = (cnt_r == TIMEOUT_C) && !rise_s;
  end

  // Next-state logic: acquisition, lock-time confirmation filter and timeout.
  always_comb begin
    state_s   = state_r;
    agree_s   = agree_r;
    cand_s    = cand_r;
    rx_data_s = rx_data_r;
    rx_chg_s  = 1'b0;
    case (state_r)
      NO_CARRIER: begin
        if (rise_s) begin
          // First edge only opens a measurement window.
          state_s = ACQ;
          agree_s = 4'd0;
        end else begin
          state_s = NO_CARRIER;
        end
      end
      ACQ: begin
        if (rise_s) begin
          if ((agree_r != 4'd0) && (cls_s == cand_r)) begin
            agree_s = agree_r + 4'd1;
          end else begin
            cand_s  = cls_s;
            agree_s = 4'd1;
          end
          if (agree_s == CONFIRM_C) begin
            state_s   = LOCK;
            rx_data_s = cand_s;
            rx_chg_s  = (cand_s != rx_data_r);
            agree_s   = 4'd0;
          end else begin
            state_s = ACQ;
          end
        end else if (timeout_s) begin
          state_s = NO_CARRIER;
          agree_s = 4'd0;
        end else begin
          state_s = ACQ;
        end
      end
      LOCK: begin
        if (rise_s) begin
          if (cls_s == rx_data_r) begin
            agree_s = 4'd0;
          end else begin
            agree_s = agree_r + 4'd1;
            if (agree_s == CONFIRM_C) begin
              rx_data_s = ~rx_data_r;
              rx_chg_s  = 1'b1;
              agree_s   = 4'd0;
            end else begin
              rx_data_s = rx_data_r;
            end
          end
        end else if (timeout_s) begin
          state_s = NO_CARRIER;
          agree_s = 4'd0;
        end else begin
          state_s = LOCK;
        end
      end
      default: begin
        state_s = NO_CARRIER;
        agree_s = 4'd0;
      end
    endcase
  end

  // Synchronizer, period counter, state and registered outputs.
  always_ff @(posedge RX_CLK) begin
    if (RESET) begin
      s1_r      <= 1'b0;
      s2_r      <= 1'b0;
      s3_r      <= 1'b0;
      cnt_r     <= '0;
      period_r  <= '0;
      agree_r   <= 4'd0;
      cand_r    <= 1'b0;
      state_r   <= NO_CARRIER;
      rx_data_r <= 1'b0;
      rx_chg_r  <= 1'b0;
      carrier_r <= 1'b0;
    end else begin
      s1_r      <= FSK_IN;
      s2_r      <= s1_r;
      s3_r      <= s2_r;
      cnt_r     <= rise_s ? '0 : cnt_inc_s;
      period_r  <= rise_s ? cnt_inc_s : period_r;
      agree_r   <= agree_s;
      cand_r    <= cand_s;
      state_r   <= state_s;
      rx_data_r <= rx_data_s;
      rx_chg_r  <= rx_chg_s;
      carrier_r <= (state_s == LOCK);
    end
  end

  assign RX_DATA = rx_data_r;
  assign RX_CHG  = rx_chg_r;
  assign CARRIER = carrier_r;
  assign PERIOD  = period_r;

endmodule

// File: tb/tb_fsk_demod.sv
// tb_fsk_demod: drives clock-aligned FSK bursts into two demodulators (normal
// and inverted decoding), checks a directed table, random class runs against
// an event-level reference model, carrier timeout and reset during lock.
module tb_fsk_demod;

  localparam int THRESH  = 16;
  localparam int CONFIRM = 3;
  localparam int TIMEOUT = 200;
  localparam int NTAB    = 29;

  logic       rx_clk = 1'b0;
  logic       reset  = 1'b1;
  logic       fsk_in = 1'b0;
  logic       rx_data [2];
  logic       rx_chg  [2];
  logic       carrier [2];
  logic [7:0] period  [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, one copy per decoding polarity.
  bit m_idle   [2];
  bit m_locked [2];
  bit m_data   [2];
  bit m_chg    [2];
  int m_chgs   [2];
  int m_wlen   [2];
  bit m_win    [2][0:14];

  int last_per  = 0;
  bit per_valid = 1'b0;

  int chg_seen [2] = '{0, 0};
  int chg_b2b  = 0;
  bit chg_prev [2] = '{1'b0, 1'b0};

  typedef struct {
    int h;
    int l;
    bit d;
    bit c;
    bit car;
    int per;
  } vec_t;
  vec_t tab [NTAB];

  fsk_demod dut0 (
    .RX_CLK (rx_clk), .RESET (reset), .FSK_IN (fsk_in),
    .RX_DATA(rx_data[0]), .RX_CHG(rx_chg[0]), .CARRIER(carrier[0]), .PERIOD(period[0])
  );

  fsk_demod #(.FAST_IS_ONE(0)) dut1 (
    .RX_CLK (rx_clk), .RESET (reset), .FSK_IN (fsk_in),
    .RX_DATA(rx_data[1]), .RX_CHG(rx_chg[1]), .CARRIER(carrier[1]), .PERIOD(period[1])
  );

  always #5 rx_clk = ~rx_clk;

  // Count RX_CHG pulses and flag any two-cycle-wide pulse.
  always @(negedge rx_clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rx_chg[m] === 1'b1) begin
        chg_seen[m] = chg_seen[m] + 1;
        if (chg_prev[m]) chg_b2b = chg_b2b + 1;
      end
      chg_prev[m] = (rx_chg[m] === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic bit fast_val(input int m);
    return (m == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic void model_reset(input bit clear_data);
    for (int m = 0; m < 2; m++) begin
      m_idle[m]   = 1'b1;
      m_locked[m] = 1'b0;
      m_wlen[m]   = 0;
      if (clear_data) m_data[m] = 1'b0;
    end
  endfunction

  // Event-level rule: after the first edge, CONFIRM consecutive periods of one
  // class (counted since the last decision) that differ from the held bit, or
  // any class while unlocked, decide the bit; a matching period while locked
  // discards the pending run.
  function automatic void model_step(input int m, input int per);
    bit cls;
    bit all_same;
    m_chg[m] = 1'b0;
    if (m_idle[m]) begin
      m_idle[m]   = 1'b0;
      m_locked[m] = 1'b0;
      m_wlen[m]   = 0;
      return;
    end
    cls = (per < THRESH) ? fast_val(m) : !fast_val(m);
    if (m_locked[m] && cls == m_data[m]) begin
      m_wlen[m] = 0;
      return;
    end
    for (int k = CONFIRM - 1; k > 0; k--) m_win[m][k] = m_win[m][k-1];
    m_win[m][0] = cls;
    if (m_wlen[m] < CONFIRM) m_wlen[m]++;
    all_same = 1'b1;
    for (int k = 0; k < CONFIRM; k++) if (m_win[m][k] != cls) all_same = 1'b0;
    if (m_wlen[m] == CONFIRM && all_same) begin
      m_chg[m]    = (cls != m_data[m]);
      m_data[m]   = cls;
      m_locked[m] = 1'b1;
      m_wlen[m]   = 0;
      if (m_chg[m]) m_chgs[m]++;
    end
  endfunction

  // Called at the negedge where a rise's effect is first visible.
  task automatic on_rise(input int idx);
    for (int m = 0; m < 2; m++) begin
      model_step(m, last_per);
      check($sformatf("dut%0d rx_data", m), 32'(rx_data[m]), 32'(m_data[m]));
      check($sformatf("dut%0d rx_chg", m), 32'(rx_chg[m]), 32'(m_chg[m]));
      check($sformatf("dut%0d carrier", m), 32'(carrier[m]), 32'(m_locked[m]));
      if (per_valid) check($sformatf("dut%0d period", m), 32'(period[m]), 32'(last_per));
    end
    if (idx >= 0) begin
      check($sformatf("tab%0d rx_data", idx), 32'(rx_data[0]), 32'(tab[idx].d));
      check($sformatf("tab%0d rx_chg", idx), 32'(rx_chg[0]), 32'(tab[idx].c));
      check($sformatf("tab%0d carrier", idx), 32'(carrier[0]), 32'(tab[idx].car));
      if (tab[idx].per >= 0)
        check($sformatf("tab%0d period", idx), 32'(period[0]), 32'(tab[idx].per));
    end
  endtask

  // One carrier period: h cycles high then l low, starting at a negedge.
  task automatic drive_period(input int h, input int l, input int idx);
    fsk_in = 1'b1;
    for (int i = 1; i <= h + l; i++) begin
      @(negedge rx_clk);
      if (i == h) fsk_in = 1'b0;
      if (i == 3) on_rise(idx);
    end
    last_per  = h + l;
    per_valid = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s dut%0d rx_data", tag, m), 32'(rx_data[m]), 32'd0);
      check($sformatf("%s dut%0d rx_chg", tag, m), 32'(rx_chg[m]), 32'd0);
      check($sformatf("%s dut%0d carrier", tag, m), 32'(carrier[m]), 32'd0);
      check($sformatf("%s dut%0d period", tag, m), 32'(period[m]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap0;
    int snap1;
    // Directed table; expectations refer to the rise at the start of each
    // record, which measures the previous record's period.
    tab[0]  = '{12, 12, 1'b0, 1'b0, 1'b0, -1};
    tab[1]  = '{12, 12, 1'b0, 1'b0, 1'b0, 24};
    tab[2]  = '{12, 12, 1'b0, 1'b0, 1'b0, 24};
    tab[3]  = '{12, 12, 1'b0, 1'b0, 1'b1, 24};
    tab[4]  = '{ 4,  4, 1'b0, 1'b0, 1'b1, 24};
    tab[5]  = '{ 4,  4, 1'b0, 1'b0, 1'b1,  8};
    tab[6]  = '{ 4,  4, 1'b0, 1'b0, 1'b1,  8};
    tab[7]  = '{12, 12, 1'b1, 1'b1, 1'b1,  8};
    tab[8]  = '{12, 12, 1'b1, 1'b0, 1'b1, 24};
    tab[9]  = '{12, 12, 1'b1, 1'b0, 1'b1, 24};
    tab[10] = '{12, 12, 1'b0, 1'b1, 1'b1, 24};
    tab[11] = '{12, 12, 1'b0, 1'b0, 1'b1, 24};
    tab[12] = '{ 4,  4, 1'b0, 1'b0, 1'b1, 24};
    tab[13] = '{ 4,  4, 1'b0, 1'b0, 1'b1,  8};
    tab[14] = '{12, 12, 1'b0, 1'b0, 1'b1,  8};
    tab[15] = '{12, 12, 1'b0, 1'b0, 1'b1, 24};
    tab[16] = '{ 4,  4, 1'b0, 1'b0, 1'b1, 24};
    tab[17] = '{ 4,  4, 1'b0, 1'b0, 1'b1,  8};
    tab[18] = '{12, 12, 1'b0, 1'b0, 1'b1,  8};
    tab[19] = '{ 8,  8, 1'b0, 1'b0, 1'b1, 24};
    tab[20] = '{ 8,  8, 1'b0, 1'b0, 1'b1, 16};
    tab[21] = '{ 8,  7, 1'b0, 1'b0, 1'b1, 16};
    tab[22] = '{ 8,  7, 1'b0, 1'b0, 1'b1, 15};
    tab[23] = '{ 8,  7, 1'b0, 1'b0, 1'b1, 15};
    tab[24] = '{ 8,  8, 1'b1, 1'b1, 1'b1, 15};
    tab[25] = '{ 8,  8, 1'b1, 1'b0, 1'b1, 16};
    tab[26] = '{ 8,  8, 1'b1, 1'b0, 1'b1, 16};
    tab[27] = '{ 4,  4, 1'b0, 1'b1, 1'b1, 16};
    tab[28] = '{ 4,  4, 1'b0, 1'b0, 1'b1,  8};

    m_chgs = '{0, 0};
    model_reset(1'b1);

    // Reset with a toggling input: outputs clear on the first reset edge.
    reset  = 1'b1;
    fsk_in = 1'($urandom_range(0, 1));
    @(negedge rx_clk);
    check_all_zero("reset");
    fsk_in = 1'($urandom_range(0, 1));
    @(negedge rx_clk);
    fsk_in = 1'b0;
    reset  = 1'b0;
    per_valid = 1'b0;

    // Directed: slow acquire, switch to fast, glitch rejection, threshold.
    for (int i = 0; i < NTAB; i++) drive_period(tab[i].h, tab[i].l, i);

    // Random runs of fast/slow periods, all well inside the timeout.
    for (int g = 0; g < 40; g++) begin
      bit fast;
      int run;
      fast = 1'($urandom_range(0, 1));
      run  = $urandom_range(1, 5);
      for (int r = 0; r < run; r++) begin
        if (fast) drive_period($urandom_range(2, 7), $urandom_range(2, 8), -1);
        else      drive_period($urandom_range(8, 20), $urandom_range(8, 20), -1);
      end
    end

    // Lock at 1 on dut0, then let the carrier stop after one last rise.
    for (int k = 0; k < 5; k++) drive_period(3, 3, -1);
    fsk_in = 1'b1;
    repeat (3) @(negedge rx_clk);
    on_rise(-1);
    check("pre-loss dut0 rx_data", 32'(rx_data[0]), 32'd1);
    snap0 = chg_seen[0];
    snap1 = chg_seen[1];
    @(negedge rx_clk);
    fsk_in = 1'b0;
    repeat (TIMEOUT - 1) @(negedge rx_clk);
    check("loss-1 dut0 carrier", 32'(carrier[0]), 32'd1);
    check("loss-1 dut1 carrier", 32'(carrier[1]), 32'd1);
    @(negedge rx_clk);
    check("loss dut0 carrier", 32'(carrier[0]), 32'd0);
    check("loss dut1 carrier", 32'(carrier[1]), 32'd0);
    check("loss dut0 rx_data", 32'(rx_data[0]), 32'd1);
    check("loss dut1 rx_data", 32'(rx_data[1]), 32'(m_data[1]));
    check("loss dut0 no rx_chg", 32'(chg_seen[0]), 32'(snap0));
    check("loss dut1 no rx_chg", 32'(chg_seen[1]), 32'(snap1));
    model_reset(1'b0);
    per_valid = 1'b0;

    // Reacquire after loss, then reset in the middle of LOCK.
    for (int k = 0; k < 6; k++) drive_period(10, 10, -1);
    check("relock dut0 carrier", 32'(carrier[0]), 32'd1);
    repeat (4) @(negedge rx_clk);
    reset  = 1'b1;
    fsk_in = 1'b1;
    @(negedge rx_clk);
    check_all_zero("lock-reset");
    reset  = 1'b0;
    fsk_in = 1'b0;
    model_reset(1'b1);
    per_valid = 1'b0;
    for (int k = 0; k < 6; k++) drive_period(5, 5, -1);

    repeat (3) @(negedge rx_clk);
    check("dut0 rx_chg pulse count", 32'(chg_seen[0]), 32'(m_chgs[0]));
    check("dut1 rx_chg pulse count", 32'(chg_seen[1]), 32'(m_chgs[1]));
    check("rx_chg back-to-back", 32'(chg_b2b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsk_demod.md
# fsk_demod

Receive-side counterpart of the FSK modem transmitter. Accepts the DCO-generated FSK waveform on `FSK_IN`, which is asynchronous to `RX_CLK`. It measures the carrier period in `RX_CLK` cycles, classifies each period as fast or slow, and recovers the transmitted bit with a consecutive-period confirmation filter. It also reports carrier presence, a bit-change strobe and the last measured period for debug and threshold calibration.

## Interface

**Parameters**
- `CNT_W`, default 8: width of the period counter and the `PERIOD` output.
- `THRESH`, default 16: period in `RX_CLK` cycles. A period below `THRESH` is fast; a period of `THRESH` or more is slow.
- `CONFIRM`, default 3: number of consecutive same-class periods needed to acquire lock or to flip `RX_DATA`. Legal range is 1..15.
- `TIMEOUT`, default 200: number of cycles without a rising edge before carrier is declared lost. Must be below 2^CNT_W−1.
- `FAST_IS_ONE`, default 1: 1 means fast carrier decodes to 1 and slow to 0; 0 inverts this.

**Ports**
- `RX_CLK`, in, 1: the only clock; all logic on its rising edge.
- `RESET`, in, 1: synchronous, active-high reset.
- `FSK_IN`, in, 1: FSK carrier, asynchronous to `RX_CLK`.
- `RX_DATA`, out, 1: recovered bit, held between changes.
- `RX_CHG`, out, 1: one-cycle pulse when `RX_DATA` changes value.
- `CARRIER`, out, 1: high while in the LOCK state.
- `PERIOD`, out, CNT_W: last measured rising-edge-to-rising-edge period.

## Operation

**Synchronizer and edge detect**
- `FSK_IN` passes through two flops, s1 then s2, to synchronize it.
- A third flop s3 holds the previous s2; `rise` = s2 & ~s3.

**Period counter `cnt`**
- Cleared to 0 in any cycle where `rise` is true.
- Otherwise increments by 1, saturating at 2^CNT_W−1.
- On `rise`, `PERIOD` ← cnt+1, saturating. Example: rises detected at cycles 10 and 18 give `PERIOD` = 8.

**Classification (only on `rise`)**
- `fast` = (cnt+1 < THRESH).
- `cls` = fast ? FAST_IS_ONE : ~FAST_IS_ONE.

**State machine and agree counter**
- A 4-bit `agree` counter tracks consecutive qualifying periods.
- NO_CARRIER (reset state):
  - The first `rise` only starts a measurement: go to ACQ with agree=0.
  - Its `PERIOD` update is still performed.
- ACQ:
  - On `rise`: if agree≠0 and cls==cand, agree++; otherwise cand←cls and agree←1.
  - When the updated agree reaches CONFIRM: go to LOCK, set CARRIER=1, set RX_DATA←cand, agree←0.
  - RX_CHG pulses on that transition only if cand differs from the held RX_DATA.
- LOCK:
  - On `rise` with cls==RX_DATA: agree←0.
  - On `rise` with cls≠RX_DATA: agree++.
  - When agree reaches CONFIRM: RX_DATA flips, RX_CHG pulses for one cycle, agree←0.
- Timeout: in ACQ or LOCK, if cnt==TIMEOUT and `rise` is false, go to NO_CARRIER next cycle.
  - CARRIER←0 and agree←0.
  - RX_DATA holds its value and RX_CHG stays 0.
- A `rise` in the same cycle as cnt==TIMEOUT is a valid edge, and the timeout is not taken.
- CONFIRM=1: each differing period flips RX_DATA immediately.

**Reset (synchronous)**
- Takes priority over all other logic, including mid-measurement and in LOCK.
- Values: s1=s2=s3=0, cnt=0, agree=0, state=NO_CARRIER.
- Outputs: RX_DATA=0, RX_CHG=0, CARRIER=0, PERIOD=0.

## Timing

- All outputs are registered.
- `FSK_IN` 0→1 first sampled high at edge n: `rise` is true in the cycle after edge n+1. `PERIOD`, `RX_DATA`, `RX_CHG` and `CARRIER` update at edge n+2. Latency is 2 cycles from capture.
- Synchronizer uncertainty: ±1 cycle per edge, so measured periods jitter by ±1. THRESH must sit at least 2 away from both nominal periods.
- Minimum measurable period is 2 cycles. FSK_IN high or low phases shorter than 1 RX_CLK cycle may be missed; this is by design.
- RX_CHG is high for exactly one cycle and never on consecutive cycles.
- Lock latency from carrier start: 1+CONFIRM rising edges.
- Bit-change latency: CONFIRM periods of the new frequency.
- Carrier-loss latency: TIMEOUT+1 cycles after the last detected `rise`.

## Test plan

1. **Reset.** Toggle FSK_IN randomly and hold RESET high for 2 cycles.
   - Required: RX_DATA=0, RX_CHG=0, CARRIER=0, PERIOD=0 after the first reset edge.
   - Required: lock is not declared before 4 more rises are detected.
2. **Slow acquire.** Continuous carrier with period 24 (12 high / 12 low), default parameters.
   - Required: CARRIER rises on the 4th detected rise; RX_DATA=0 with no RX_CHG pulse; PERIOD=24.
3. **Switch to fast.** While locked at 0, change to period 8.
   - Required: RX_DATA→1 on the 3rd fast rise with a single RX_CHG pulse; PERIOD=8; CARRIER stays 1.
4. **Glitch rejection.** Inside a period-24 stream locked at 0, insert two period-8 cycles, then return to 24.
   - Required: RX_DATA stays 0, no RX_CHG pulse, agree cleared.
   - Repeat with FAST_IS_ONE=0 and confirm inverted decoding.
5. **Threshold boundary.** Use clock-aligned (jitter-free) FSK_IN: periods of exactly 16 classify as slow, periods of 15 classify as fast. Verify via the RX_DATA outcome after 3 periods of each.
6. **Carrier loss and reset mid-LOCK.**
   - Hold FSK_IN low after locking at 1: CARRIER falls 201 cycles after the last rise, RX_DATA stays 1, no RX_CHG.
   - Separately, assert RESET during LOCK: all outputs are 0 at the next edge.
